// File: rtl/mem_port_arbiter.sv
// Shares one physical memory port between instruction fetch and data access.
// Data wins ties unless imem has been passed over STARVE_LIMIT times in a row.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_read,
    input  logic [31:0] imem_address,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [31:0] dmem_address,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_mbe,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_address,
    output logic [31:0] pmem_wdata,
    output logic [3:0]  pmem_mbe,
    input  logic [31:0] pmem_rdata,
    input  logic        pmem_resp
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 4;
    localparam int unsigned CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;
    typedef enum logic [1:0] {MASK_NONE, MASK_I, MASK_D} mask_t;

    typedef struct packed {
        logic [AW-1:0] address;
        logic [DW-1:0] wdata;
        logic [MW-1:0] mbe;
    } pmem_req_t;

    state_t    state, state_nxt;
    mask_t     mask, mask_nxt;
    logic [CW-1:0] starve_cnt, starve_cnt_nxt;
    pmem_req_t req_q, req_nxt;
    logic      rd_nxt, wr_nxt;
    logic      dmem_req, imem_req, force_i;

    // State and all registered pmem-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mask       <= MASK_NONE;
            starve_cnt <= '0;
            req_q      <= '0;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
        end else begin
            state      <= state_nxt;
            mask       <= mask_nxt;
            starve_cnt <= starve_cnt_nxt;
            req_q      <= req_nxt;
            pmem_read  <= rd_nxt;
            pmem_write <= wr_nxt;
        end
    end

    assign pmem_address = req_q.address;
    assign pmem_wdata   = req_q.wdata;
    assign pmem_mbe     = req_q.mbe;

    // Arbitration: the requester just served sits out exactly one IDLE cycle.
    always_comb begin
        state_nxt = state;
        dmem_req  = (dmem_read || dmem_write) && (mask != MASK_D);
        imem_req  = imem_read && (mask != MASK_I);
        force_i   = (STARVE_LIMIT != 0) && (starve_cnt == CW'(STARVE_LIMIT));
        case (state)
            IDLE: begin
                if (dmem_req && imem_req) state_nxt = force_i ? GRANT_I : GRANT_D;
                else if (dmem_req)        state_nxt = GRANT_D;
                else if (imem_req)        state_nxt = GRANT_I;
            end
            GRANT_I, GRANT_D: begin
                if (pmem_resp) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Response forwarding and next values for the latched pmem request.
    always_comb begin
        imem_resp      = 1'b0;
        imem_rdata     = '0;
        dmem_resp      = 1'b0;
        dmem_rdata     = '0;
        req_nxt        = req_q;
        rd_nxt         = pmem_read;
        wr_nxt         = pmem_write;
        mask_nxt       = MASK_NONE;
        starve_cnt_nxt = starve_cnt;

        if (state == IDLE && state_nxt == GRANT_I) begin
            rd_nxt         = 1'b1;
            wr_nxt         = 1'b0;
            req_nxt        = '{address: imem_address, wdata: '0, mbe: '1};
            starve_cnt_nxt = '0;
        end else if (state == IDLE && state_nxt == GRANT_D) begin
            // A read+write collision resolves to a write.
            rd_nxt  = !dmem_write;
            wr_nxt  = dmem_write;
            req_nxt = '{address: dmem_address, wdata: dmem_wdata,
                        mbe: dmem_write ? dmem_mbe : {MW{1'b1}}};
            if (imem_read && starve_cnt != CW'(STARVE_LIMIT))
                starve_cnt_nxt = starve_cnt + CW'(1);
        end

        if (state == GRANT_I && pmem_resp) begin
            imem_resp  = 1'b1;
            imem_rdata = pmem_rdata;
            rd_nxt     = 1'b0;
            wr_nxt     = 1'b0;
            mask_nxt   = MASK_I;
        end
        if (state == GRANT_D && pmem_resp) begin
            dmem_resp  = 1'b1;
            dmem_rdata = pmem_rdata;
            rd_nxt     = 1'b0;
            wr_nxt     = 1'b0;
            mask_nxt   = MASK_D;
        end
    end

    a_no_rw_collision : assert property (@(posedge clk) disable iff (!rst)
        !(dmem_read && dmem_write))
        else $warning("dmem_read and dmem_write both high; access handled as a write");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a cycle-level
// behavioural model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_read = 1'b0;
    logic [31:0] imem_address = '0;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        dmem_read = 1'b0;
    logic        dmem_write = 1'b0;
    logic [31:0] dmem_address = '0;
    logic [31:0] dmem_wdata = '0;
    logic [3:0]  dmem_mbe = '0;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [31:0] pmem_wdata;
    logic [3:0]  pmem_mbe;
    logic [31:0] pmem_rdata = '0;
    logic        pmem_resp = 1'b0;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .imem_read(imem_read), .imem_address(imem_address),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_address(dmem_address), .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_mbe(pmem_mbe),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who owns the port, who sits out, how often imem lost.
    localparam int OWN_NONE = 0;
    localparam int OWN_I    = 1;
    localparam int OWN_D    = 2;
    int          owner, benched;
    int unsigned passed_over;
    logic        m_rd, m_wr;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_mbe;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        owner = OWN_NONE; benched = OWN_NONE; passed_over = 0;
        m_rd = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_mbe = '0;
    endfunction

    // Advance the model by one rising edge using the inputs held this cycle.
    function automatic void model_edge();
        bit want_d, want_i;
        int win;
        if (!rst) begin
            model_reset();
            return;
        end
        if (owner == OWN_NONE) begin
            want_d = (dmem_read || dmem_write) && benched != OWN_D;
            want_i = imem_read && benched != OWN_I;
            benched = OWN_NONE;
            if (want_d && want_i)
                win = (LIMIT != 0 && passed_over == LIMIT) ? OWN_I : OWN_D;
            else
                win = want_d ? OWN_D : (want_i ? OWN_I : OWN_NONE);
            owner = win;
            if (win == OWN_I) begin
                passed_over = 0;
                m_rd = 1'b1; m_wr = 1'b0;
                m_addr = imem_address; m_wdata = '0; m_mbe = 4'hF;
            end else if (win == OWN_D) begin
                if (imem_read && passed_over < LIMIT) passed_over++;
                m_wr = dmem_write; m_rd = !dmem_write;
                m_addr = dmem_address; m_wdata = dmem_wdata;
                m_mbe = dmem_write ? dmem_mbe : 4'hF;
            end
        end else if (pmem_resp) begin
            benched = owner;
            owner = OWN_NONE;
            m_rd = 1'b0; m_wr = 1'b0;
        end
    endfunction

    task automatic check_outputs();
        logic ei, ed;
        ei = (owner == OWN_I) && pmem_resp;
        ed = (owner == OWN_D) && pmem_resp;
        check_eq("pmem_read",    32'(pmem_read),  32'(m_rd));
        check_eq("pmem_write",   32'(pmem_write), 32'(m_wr));
        check_eq("pmem_address", pmem_address, m_addr);
        check_eq("pmem_wdata",   pmem_wdata, m_wdata);
        check_eq("pmem_mbe",     32'(pmem_mbe), 32'(m_mbe));
        check_eq("imem_resp",    32'(imem_resp), 32'(ei));
        check_eq("imem_rdata",   imem_rdata, ei ? pmem_rdata : 32'h0);
        check_eq("dmem_resp",    32'(dmem_resp), 32'(ed));
        check_eq("dmem_rdata",   dmem_rdata, ed ? pmem_rdata : 32'h0);
    endtask

    task automatic sample();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic cycle_end();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic quiet_inputs();
        imem_read = 1'b0; dmem_read = 1'b0; dmem_write = 1'b0; pmem_resp = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        quiet_inputs();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cycle_end();
    endtask

    int d_grants;
    bit got_i, saw_i, saw_d;
    int r;

    initial begin
        model_reset();
        do_reset();

        // Reset state
        sample();
        check_eq("rst_pmem_read",  32'(pmem_read), 32'h0);
        check_eq("rst_pmem_write", 32'(pmem_write), 32'h0);
        check_eq("rst_pmem_addr",  pmem_address, 32'h0);
        cycle_end();

        // Lone fetch
        imem_read = 1'b1; imem_address = 32'h60;
        sample();
        cycle_end();
        pmem_resp = 1'b1; pmem_rdata = 32'h13;
        sample();
        check_eq("fetch_strobe", 32'(pmem_read), 32'h1);
        check_eq("fetch_addr",   pmem_address, 32'h60);
        check_eq("fetch_resp",   32'(imem_resp), 32'h1);
        check_eq("fetch_rdata",  imem_rdata, 32'h13);
        cycle_end();
        quiet_inputs();
        sample();
        cycle_end();

        // Simultaneous requests: data first, then fetch
        imem_read = 1'b1; imem_address = 32'h80;
        dmem_write = 1'b1; dmem_address = 32'h100; dmem_wdata = 32'hDEADBEEF; dmem_mbe = 4'b0011;
        sample();
        cycle_end();
        pmem_resp = 1'b1;
        sample();
        check_eq("tie_write",  32'(pmem_write), 32'h1);
        check_eq("tie_mbe",    32'(pmem_mbe), 32'h3);
        check_eq("tie_addr",   pmem_address, 32'h100);
        check_eq("tie_wdata",  pmem_wdata, 32'hDEADBEEF);
        check_eq("tie_dresp",  32'(dmem_resp), 32'h1);
        check_eq("tie_iresp0", 32'(imem_resp), 32'h0);
        cycle_end();
        dmem_write = 1'b0; pmem_resp = 1'b0;
        sample();
        check_eq("tie_gap", 32'(pmem_read), 32'h0);
        cycle_end();
        pmem_resp = 1'b1;
        sample();
        check_eq("tie_then_i", 32'(pmem_read), 32'h1);
        check_eq("tie_i_addr", pmem_address, 32'h80);
        cycle_end();
        quiet_inputs();
        sample();
        cycle_end();

        // Held-over dmem_read must not be re-granted in the following IDLE cycle
        dmem_read = 1'b1; dmem_address = 32'h300;
        sample();
        cycle_end();
        pmem_resp = 1'b1;
        sample();
        cycle_end();
        pmem_resp = 1'b0;
        sample();
        cycle_end();
        dmem_read = 1'b0;
        sample();
        check_eq("mask_no_regrant", 32'(pmem_read), 32'h0);
        cycle_end();

        // Read+write collision is a write
        dmem_read = 1'b1; dmem_write = 1'b1; dmem_address = 32'h340; dmem_mbe = 4'hA;
        sample();
        cycle_end();
        pmem_resp = 1'b1;
        sample();
        check_eq("rw_write", 32'(pmem_write), 32'h1);
        check_eq("rw_read",  32'(pmem_read), 32'h0);
        cycle_end();
        quiet_inputs();
        sample();
        cycle_end();

        // Reset in the middle of a data write
        dmem_write = 1'b1; dmem_address = 32'h500; dmem_wdata = 32'h1234; dmem_mbe = 4'hF;
        sample();
        cycle_end();
        sample();
        check_eq("pre_rst_write", 32'(pmem_write), 32'h1);
        rst = 1'b0;
        model_reset();
        quiet_inputs();
        #1;
        check_eq("async_rst_write", 32'(pmem_write), 32'h0);
        cycle_end();
        @(negedge clk);
        rst = 1'b1;
        cycle_end();
        pmem_resp = 1'b1; pmem_rdata = 32'hABCD;
        sample();
        check_eq("late_resp_dropped", 32'(dmem_resp), 32'h0);
        cycle_end();
        quiet_inputs();

        // Starvation: imem only loses when dmem contends; forced after LIMIT losses
        do_reset();
        imem_read = 1'b1; imem_address = 32'h400;
        dmem_read = 1'b1; dmem_address = 32'h200;
        d_grants = 0; got_i = 0;
        for (int c = 0; c < 80 && !got_i; c++) begin
            pmem_resp = pmem_read | pmem_write;
            pmem_rdata = $urandom;
            sample();
            saw_d = dmem_resp;
            if (imem_resp) got_i = 1;
            else if (dmem_resp) d_grants++;
            cycle_end();
            imem_read = !saw_d;
        end
        check_eq("starve_i_granted", 32'(got_i), 32'h1);
        check_eq("starve_d_grants", 32'(d_grants), 32'(LIMIT));
        quiet_inputs();
        sample();
        cycle_end();

        // Randomized traffic: protocol-abiding first half, free toggling second half
        saw_i = 0; saw_d = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c < 2000) begin
                if (imem_read) begin
                    if (saw_i && ($urandom % 4) != 0) imem_read = 1'b0;
                end else imem_read = 1'($urandom % 2);
                if (dmem_read || dmem_write) begin
                    if (saw_d && ($urandom % 4) != 0) begin dmem_read = 1'b0; dmem_write = 1'b0; end
                end else begin
                    r = int'($urandom % 4);
                    dmem_read = (r == 1); dmem_write = (r == 2);
                end
            end else begin
                imem_read = 1'($urandom % 2);
                r = int'($urandom % 3);
                dmem_read = (r == 1); dmem_write = (r == 2);
            end
            imem_address = $urandom; dmem_address = $urandom;
            dmem_wdata = $urandom; dmem_mbe = 4'($urandom);
            pmem_resp = (pmem_read || pmem_write) ? (($urandom % 3) == 0) : (($urandom % 8) == 0);
            pmem_rdata = $urandom;
            sample();
            saw_i = imem_resp; saw_d = dmem_resp;
            cycle_end();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
